// File: rtl/wb_ctrl_pkg.sv
// Shared constants and types for the register-bank writeback path.
// The entry type describes one pending write: destination register and result data.
package wb_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // One-hot register mask; x0 never produces a bit since it is hardwired zero.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != X0) m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding load results waiting for a free writeback slot.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: merges ALU and buffered load results onto the bank's single
// write port and tracks which registers still await a load writeback.
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            we,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic [31:0]     pending,
    output logic            err
);

    localparam int EW = REG_ADDR_W + XLEN;

    logic [EW-1:0]         fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  ld_acc;
    logic                  sel_pop;
    logic                  sel_byp;
    logic                  fifo_push;
    logic [NUM_REGS-1:0]   pend_clr;
    logic [NUM_REGS-1:0]   pending_nxt;
    logic                  err_evt;

    assign head_rd   = fifo_head[EW-1:XLEN];
    assign head_data = fifo_head[XLEN-1:0];

    // ALU wins the port; buffered loads drain before a fresh load may bypass.
    assign ld_ready  = !fifo_full;
    assign ld_acc    = ld_valid && ld_ready;
    assign sel_pop   = !alu_valid && !fifo_empty;
    assign sel_byp   = !alu_valid && fifo_empty && ld_acc;
    assign fifo_push = ld_acc && !sel_byp;

    wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({ld_rd, ld_data}),
        .pop   (sel_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        pend_clr = '0;
        if (sel_pop)      pend_clr = reg_mask(head_rd);
        else if (sel_byp) pend_clr = reg_mask(ld_rd);
        // A same-cycle issue to the register being cleared must keep it pending.
        pending_nxt = (pending & ~pend_clr) | (ld_issue ? reg_mask(ld_issue_rd) : '0);
    end

    assign err_evt = (ld_issue && pending[ld_issue_rd])
                   || (alu_valid && (alu_rd != X0) && pending[alu_rd])
                   || (ld_valid && !ld_ready)
                   || (ld_valid && !pending[ld_rd]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            a3      <= '0;
            wd3     <= '0;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (err_evt) err <= 1'b1;
            if (alu_valid) begin
                we  <= (alu_rd != X0);
                a3  <= alu_rd;
                wd3 <= alu_data;
            end else if (sel_pop) begin
                we  <= (head_rd != X0);
                a3  <= head_rd;
                wd3 <= head_data;
            end else if (sel_byp) begin
                we  <= (ld_rd != X0);
                a3  <= ld_rd;
                wd3 <= ld_data;
            end else begin
                we  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            we;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic [31:0]     pending;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic            m_we;
    logic [4:0]      m_a3;
    logic [XLEN-1:0] m_wd3;
    logic [31:0]     m_pend;
    logic            m_err;
    logic [36:0]     exp_q[$];

    wb_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .we          (we),
        .a3          (a3),
        .wd3         (wd3),
        .pending     (pending),
        .err         (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic m_ready();
        return exp_q.size() < DEPTH;
    endfunction

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
    endtask

    task automatic model_reset();
        m_we = 0; m_a3 = 0; m_wd3 = 0; m_pend = 0; m_err = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    // Advance model by one cycle from the current inputs, then clock the DUT.
    task automatic step();
        logic        ready, acc;
        logic [36:0] e;
        ready = m_ready();
        acc   = ld_valid && ready;
        if ((ld_issue && m_pend[ld_issue_rd]) ||
            (alu_valid && alu_rd != 0 && m_pend[alu_rd]) ||
            (ld_valid && !ready) ||
            (ld_valid && !m_pend[ld_rd]))
            m_err = 1;
        if (alu_valid) begin
            m_we = (alu_rd != 0); m_a3 = alu_rd; m_wd3 = alu_data;
            if (acc) exp_q.push_back({ld_rd, ld_data});
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_we = (e[36:32] != 0); m_a3 = e[36:32]; m_wd3 = e[31:0];
            m_pend[e[36:32]] = 0;
            if (acc) exp_q.push_back({ld_rd, ld_data});
        end else if (acc) begin
            m_we = (ld_rd != 0); m_a3 = ld_rd; m_wd3 = ld_data;
            m_pend[ld_rd] = 0;
        end else begin
            m_we = 0;
        end
        if (ld_issue && ld_issue_rd != 0) m_pend[ld_issue_rd] = 1;
        m_pend[0] = 0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++; if (we !== 1'b0)       begin n_fail++; $display("FAIL reset_we got %0b want 0", we); end
        n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h want 0", pending); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %0b want 1", ld_ready); end
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
        n_checks++; if (a3 !== 5'd0 || wd3 !== 32'h0) begin n_fail++; $display("FAIL reset_a3_wd3 got %0d/%h want 0/0", a3, wd3); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            idle_inputs(); ld_issue = 1; ld_issue_rd = 5'(i); step();
        end
        for (int i = 1; i <= 3; i++) begin
            idle_inputs();
            alu_valid = 1; alu_rd = 5'(16 + i); alu_data = 32'(i);
            ld_valid = 1; ld_rd = 5'(i); ld_data = 32'h100 + 32'(i);
            step();
        end
        idle_inputs();
        n_checks++; if (pending !== 32'h0000_000E) begin n_fail++; $display("FAIL mid_pending_before got %h want 0000000e", pending); end
        n_checks++; if (exp_q.size() != 3 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL mid_buffered got q=%0d ready=%0b want 3/1", exp_q.size(), ld_ready); end
        rst_n = 0;
        model_reset();
        #1;
        n_checks++; if (we !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_we got %0b want 0", we); end
        n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pending got %h want 0", pending); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ld_ready got %0b want 1", ld_ready); end
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_err got %0b want 0", err); end
        @(posedge clk); #1;
        rst_n = 1;
        step();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_drain got we=%0b want 0", we); end
    endtask

    task automatic test_alu();
        apply_reset();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        n_checks++; if (we !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_write got we=%0b a3=%0d wd3=%h want 1/5/deadbeef", we, a3, wd3); end
        step();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop got %0b want 0", we); end
        n_checks++; if (a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_hold got %0d/%h want 5/deadbeef", a3, wd3); end
    endtask

    task automatic test_bypass();
        idle_inputs(); ld_issue = 1; ld_issue_rd = 7; step();
        n_checks++; if (pending[7] !== 1'b1) begin n_fail++; $display("FAIL byp_pending_set got %0b want 1", pending[7]); end
        idle_inputs(); ld_valid = 1; ld_rd = 7; ld_data = 32'h1234; step();
        idle_inputs();
        n_checks++; if (we !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h1234) begin
            n_fail++; $display("FAIL byp_write got we=%0b a3=%0d wd3=%h want 1/7/1234", we, a3, wd3); end
        n_checks++; if (pending[7] !== 1'b0) begin n_fail++; $display("FAIL byp_pending_clr got %0b want 0", pending[7]); end
        step();
        n_checks++; if (we !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL byp_fifo_empty got we=%0b err=%0b want 0/0", we, err); end
    endtask

    task automatic test_collision();
        idle_inputs(); ld_issue = 1; ld_issue_rd = 9; step();
        idle_inputs();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
        ld_valid = 1; ld_rd = 9; ld_data = 32'h9999;
        step();
        idle_inputs();
        n_checks++; if (we !== 1'b1 || a3 !== 5'd3 || wd3 !== 32'h3333) begin
            n_fail++; $display("FAIL coll_alu got we=%0b a3=%0d wd3=%h want 1/3/3333", we, a3, wd3); end
        n_checks++; if (pending[9] !== 1'b1) begin n_fail++; $display("FAIL coll_pend_held got %0b want 1", pending[9]); end
        step();
        n_checks++; if (we !== 1'b1 || a3 !== 5'd9 || wd3 !== 32'h9999) begin
            n_fail++; $display("FAIL coll_load got we=%0b a3=%0d wd3=%h want 1/9/9999", we, a3, wd3); end
        n_checks++; if (pending[9] !== 1'b0) begin n_fail++; $display("FAIL coll_pend_clr got %0b want 0", pending[9]); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); ld_issue = 1; ld_issue_rd = 5'(11 + i); step();
        end
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            alu_valid = 1; alu_rd = 5'(20 + c); alu_data = 32'hC0 + 32'(c);
            if (c < 5) begin
                ld_valid = 1; ld_rd = 5'(11 + c); ld_data = 32'hA0 + 32'(c);
            end
            step();
            n_checks++; if (we !== 1'b1 || a3 !== 5'(20 + c)) begin
                n_fail++; $display("FAIL full_alu%0d got we=%0b a3=%0d want 1/%0d", c, we, a3, 20 + c); end
            if (c == 3) begin
                n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", ld_ready); end
                n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err_early got %0b want 0", err); end
            end
            if (c == 4) begin
                n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL full_overflow_err got %0b want 1", err); end
            end
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (we !== 1'b1 || a3 !== 5'(11 + i) || wd3 !== 32'hA0 + 32'(i)) begin
                n_fail++; $display("FAIL full_drain%0d got we=%0b a3=%0d wd3=%h want 1/%0d/%h", i, we, a3, wd3, 11 + i, 32'hA0 + i); end
        end
        step();
        n_checks++; if (we !== 1'b0 || ld_ready !== 1'b1 || pending !== m_pend || pending !== 32'h0) begin
            n_fail++; $display("FAIL full_after got we=%0b ready=%0b pend=%h want 0/1/0", we, ld_ready, pending); end
    endtask

    task automatic test_x0_waw();
        apply_reset();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h5555; step();
        idle_inputs();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_we got %0b want 0", we); end
        ld_issue = 1; ld_issue_rd = 4; step();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL waw_first got err=%0b want 0", err); end
        step();
        idle_inputs();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL waw_err got %0b want 1", err); end
        step();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", err); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 49) apply_reset();
            idle_inputs();
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            ld_issue    = ($urandom_range(0, 2) == 0);
            ld_issue_rd = 5'($urandom_range(0, 7));
            ld_valid    = ($urandom_range(0, 1) == 0);
            ld_rd       = 5'($urandom_range(0, 7));
            ld_data     = $urandom;
            step();
            n_checks++; if (we !== m_we || a3 !== m_a3 || wd3 !== m_wd3) begin
                n_fail++; $display("FAIL rand_port[%0d] got %0b/%0d/%h want %0b/%0d/%h", i, we, a3, wd3, m_we, m_a3, m_wd3); end
            n_checks++; if (pending !== m_pend) begin
                n_fail++; $display("FAIL rand_pending[%0d] got %h want %h", i, pending, m_pend); end
            n_checks++; if (err !== m_err || ld_ready !== m_ready()) begin
                n_fail++; $display("FAIL rand_flags[%0d] got err=%0b ready=%0b want %0b/%0b", i, err, ld_ready, m_err, m_ready()); end
            n_checks++; if (m_we && a3 === 5'd0) begin
                n_fail++; $display("FAIL rand_x0_write[%0d] got we=1 a3=0 want no x0 write", i); end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        test_reset();
        test_reset_mid();
        test_alu();
        test_bypass();
        test_collision();
        test_fifo_full();
        test_x0_waw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback controller: the initiator for the register bank's single write port. It drives the bank's we, a3 and wd3 inputs.
- Merges two result sources onto that one port:
  - ALU results, which are single-cycle and cannot be back-pressured.
  - Load results, which are variable-latency and buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard that the issue/hazard logic uses to stall readers of registers not yet written back.

Parameters:
- XLEN, 32, data width of results and of wd3.
- DEPTH, 4, load-result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_issue  in  1  a load was issued this cycle.
- ld_issue_rd  in  5  destination of the issued load.
- ld_valid  in  1  load data returned from memory.
- ld_rd  in  5  load destination.
- ld_data  in  XLEN  load data.
- ld_ready  out  1  FIFO can accept; equals not-full.
- we  out  1  to bank write enable (registered).
- a3  out  5  to bank write address (registered).
- wd3  out  XLEN  to bank write data (registered).
- pending  out  32  bit r set while a load to register r is outstanding; bit 0 is constant 0.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0):
  - we=0, a3=0, wd3=0, pending=0, err=0.
  - FIFO emptied: pointers and count 0, so ld_ready=1 after reset.
  - A reset asserted mid-operation discards all buffered loads and pending bits.
- Load accept:
  - A load is accepted when ld_valid && ld_ready.
  - ld_valid while ld_ready=0: the data is dropped and err is set.
- Per-cycle source select, in strict priority:
  1. alu_valid: output register loads {1, alu_rd, alu_data}.
  2. FIFO non-empty: pop the head and load it into the output register.
  3. FIFO empty and an accepted load this cycle: bypass. The load goes straight to the output register and is not pushed.
  4. Otherwise: we=0 next cycle; a3 and wd3 hold their values.
- Loads not consumed by bypass are pushed into the FIFO.
  - Push and pop may happen in the same cycle; count is unchanged.
  - Because ld_ready = !full, there is no push when full, even if a pop occurs that cycle.
- Latency:
  - ALU: 1 cycle (input at edge N gives we=1 after edge N+1).
  - Load: 1 cycle when bypassed.
  - A buffered load waits 1 cycle plus one cycle per ALU-occupied cycle ahead of it; FIFO order is preserved.
- x0 handling:
  - A selected entry with rd=0 still consumes its slot, but drives we=0.
  - The bank never sees we=1 with a3=0.
- Scoreboard:
  - ld_issue with ld_issue_rd≠0 sets pending[rd].
  - When a load entry is selected for output (bypass or pop), pending[its rd] is cleared at that same edge, so the pending bit falls the cycle we rises.
  - If an issue and a clear target the same register in the same cycle, the set wins.
- err is set, and stays set until reset, on any of:
  - ld_issue to a register whose pending bit is already set (WAW on load).
  - alu_valid with pending[alu_rd]=1 and alu_rd≠0.
  - ld_valid with ld_ready=0.
  - ld_valid whose ld_rd has pending=0.
- Pointer arithmetic: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package holds:
  - Constants REG_ADDR_W=5, NUM_REGS=32, X0=0.
  - A writeback-entry typedef {rd[4:0], data[XLEN-1:0]}.
- One sub-module, wb_fifo: a synchronous FIFO with push, pop, head, full and empty, plus async active-low reset.
- Selection, output register and scoreboard live in wb_ctrl.

Test Plan:
- Reset mid-stream: 3 loads buffered, pending=0x0000_000E, rst_n pulsed low → we=0, pending=0, ld_ready=1, err=0 immediately, without waiting for a clock edge.
- ALU only: alu_valid, rd=5, data=0xDEADBEEF at edge N → after edge N+1: we=1, a3=5, wd3=0xDEADBEEF; the following cycle we=0.
- Load bypass: ld_issue rd=7, then ld_valid rd=7, data=0x1234 with ALU idle → next cycle we=1, a3=7, pending[7] falls in that same cycle, FIFO stays empty.
- Collision: ALU rd=3 and load rd=9 in the same cycle → cycle+1 writes x3, cycle+2 writes x9; pending[9] stays set until cycle+2.
- FIFO full: ALU valid for 6 consecutive cycles while 4 loads arrive → ld_ready=0 after the 4th load. When the ALU goes idle, writes drain in arrival order over 4 cycles. A 5th ld_valid sent while full sets err.
- x0 and WAW: ALU rd=0 → we stays 0. Two ld_issue to rd=4 without an intervening writeback → err=1.
